// File: rtl/hw_accel_stream_packer_if.sv
// Stream bundle between the pixel source, the packer and the word sink.
// The pixel side carries valid/ready/eof; the word side carries
// valid/ready plus a byte-enable mask and a frame-final flag.
interface hw_accel_stream_packer_if #(
    parameter int IN_WIDTH  = 24,
    parameter int OUT_WIDTH = 32
);
    localparam int OUT_BYTES = OUT_WIDTH / 8;

    logic [IN_WIDTH-1:0]  in_data;
    logic                 in_valid;
    logic                 in_eof;
    logic                 in_ready;

    logic [OUT_WIDTH-1:0] out_data;
    logic [OUT_BYTES-1:0] out_byte_en;
    logic                 out_last;
    logic                 out_valid;
    logic                 out_ready;

    // Source/sink side: supplies pixels and the downstream ready.
    modport master (
        output in_data, in_valid, in_eof, out_ready,
        input  in_ready, out_data, out_byte_en, out_last, out_valid
    );

    // Packer side: consumes pixels and produces packed words.
    modport slave (
        input  in_data, in_valid, in_eof, out_ready,
        output in_ready, out_data, out_byte_en, out_last, out_valid
    );
endinterface

// File: rtl/hw_accel_stream_packer.sv
// Pixel-to-word packer for the hw_accel datapath.
// Pixels of IN_WIDTH bits are appended, byte by byte, to a FIFO-ordered
// byte accumulator; whenever OUT_BYTES bytes are available and the output
// register is free, the oldest OUT_BYTES bytes leave as one word (oldest
// byte in [7:0]). An accepted in_eof starts a flush that drains full words
// and then a zero-padded partial word with a byte mask, tagged out_last.
module hw_accel_stream_packer #(
    parameter int IN_WIDTH   = 24,
    parameter int OUT_WIDTH  = 32,
    parameter int BYTE_ORDER = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    hw_accel_stream_packer_if.slave bus
);
    localparam int IN_BYTES  = IN_WIDTH / 8;
    localparam int OUT_BYTES = OUT_WIDTH / 8;
    localparam int ACC_BYTES = IN_BYTES + OUT_BYTES;
    localparam int ACC_W     = ACC_BYTES * 8;
    // Wide enough to hold count + IN_BYTES without wrapping.
    localparam int CNT_W     = $clog2(ACC_BYTES + IN_BYTES + 1);

    localparam logic [CNT_W-1:0] IN_B  = CNT_W'(IN_BYTES);
    localparam logic [CNT_W-1:0] OUT_B = CNT_W'(OUT_BYTES);
    localparam logic [CNT_W-1:0] ACC_B = CNT_W'(ACC_BYTES);

    // Reorders a pixel so that stream byte k sits at bits [8k+7:8k].
    function automatic logic [IN_WIDTH-1:0] stream_order(input logic [IN_WIDTH-1:0] px);
        logic [IN_WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < IN_BYTES; k++) begin
            if (BYTE_ORDER == 0) begin
                r[k*8 +: 8] = px[(IN_BYTES-1-k)*8 +: 8];
            end else begin
                r[k*8 +: 8] = px[k*8 +: 8];
            end
        end
        return r;
    endfunction

    // Control state
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 flush_q, flush_d;

    // Output stage
    logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic [OUT_BYTES-1:0] out_byte_en_q, out_byte_en_d;
    logic                 out_last_q, out_last_d;
    logic                 out_valid_q, out_valid_d;

    // Byte accumulator, stream byte 0 (oldest) in the low byte
    logic [ACC_W-1:0]     acc_q, acc_d;

    // Datapath helpers
    logic                 in_ready_c;
    logic                 accept;
    logic [CNT_W-1:0]     avail;
    logic [CNT_W+2:0]     shamt;
    logic [ACC_W-1:0]     acc_mask;
    logic [ACC_W-1:0]     merged;
    logic                 stage_free;
    logic                 eof_pend;
    logic                 load_full;
    logic                 load_part;

    // Space for a whole pixel is judged on the registered count only, so
    // in_ready never depends on what the output side does this cycle.
    assign in_ready_c = rst & ~flush_q & ((count_q + IN_B) <= ACC_B);
    assign accept     = bus.in_valid & in_ready_c;
    assign avail      = count_q + (accept ? IN_B : '0);

    // Bytes at or above count_q are don't-care (e.g. left over from a reset
    // mid-frame), so they are masked before the new pixel is merged in.
    assign shamt      = {count_q, 3'b000};
    assign acc_mask   = ~({ACC_W{1'b1}} << shamt);
    assign merged     = (acc_q & acc_mask)
                      | (accept ? (ACC_W'(stream_order(bus.in_data)) << shamt) : '0);

    assign stage_free = ~out_valid_q | bus.out_ready;
    // The eof of a pixel accepted this cycle already counts for tagging.
    assign eof_pend   = flush_q | (accept & bus.in_eof);
    assign load_full  = stage_free & (avail >= OUT_B);
    assign load_part  = stage_free & eof_pend & (avail != '0) & (avail < OUT_B);

    // Next state for the output stage, byte count, accumulator and flush flag.
    always_comb begin
        out_data_d    = out_data_q;
        out_byte_en_d = out_byte_en_q;
        out_last_d    = out_last_q;
        out_valid_d   = out_valid_q;
        count_d       = avail;
        acc_d         = merged;
        flush_d       = eof_pend;
        if (load_full) begin
            out_data_d    = merged[OUT_WIDTH-1:0];
            out_byte_en_d = '1;
            out_last_d    = eof_pend && (avail == OUT_B);
            out_valid_d   = 1'b1;
            count_d       = avail - OUT_B;
            acc_d         = merged >> OUT_WIDTH;
            if (eof_pend && (avail == OUT_B)) begin
                flush_d = 1'b0;
            end
        end else if (load_part) begin
            // Bytes beyond avail are already zero in merged: zero padding.
            out_data_d    = merged[OUT_WIDTH-1:0];
            out_byte_en_d = ~({OUT_BYTES{1'b1}} << avail);
            out_last_d    = 1'b1;
            out_valid_d   = 1'b1;
            count_d       = '0;
            flush_d       = 1'b0;
        end else if (stage_free) begin
            out_valid_d   = 1'b0;
        end
    end

    // Control and output registers; reset discards any partial frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q       <= '0;
            flush_q       <= 1'b0;
            out_data_q    <= '0;
            out_byte_en_q <= '0;
            out_last_q    <= 1'b0;
            out_valid_q   <= 1'b0;
        end else begin
            count_q       <= count_d;
            flush_q       <= flush_d;
            out_data_q    <= out_data_d;
            out_byte_en_q <= out_byte_en_d;
            out_last_q    <= out_last_d;
            out_valid_q   <= out_valid_d;
        end
    end

    // Accumulator payload; only bytes below count_q are ever meaningful.
    always_ff @(posedge clk) begin
        acc_q <= acc_d;
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.out_data    = out_data_q;
    assign bus.out_byte_en = out_byte_en_q;
    assign bus.out_last    = out_last_q;
    assign bus.out_valid   = out_valid_q;

endmodule

// File: tb/tb_hw_accel_stream_packer.sv
// Directed bench for hw_accel_stream_packer: three instances
// (24->32 MSB-first, 24->32 LSB-first, 24->8 MSB-first) share clk/rst.
module tb_hw_accel_stream_packer;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hw_accel_stream_packer_if #(.IN_WIDTH(24), .OUT_WIDTH(32)) if0 ();
    hw_accel_stream_packer_if #(.IN_WIDTH(24), .OUT_WIDTH(32)) if1 ();
    hw_accel_stream_packer_if #(.IN_WIDTH(24), .OUT_WIDTH(8))  if2 ();

    hw_accel_stream_packer #(.IN_WIDTH(24), .OUT_WIDTH(32), .BYTE_ORDER(0)) u0 (
        .clk(clk), .rst(rst), .bus(if0.slave));
    hw_accel_stream_packer #(.IN_WIDTH(24), .OUT_WIDTH(32), .BYTE_ORDER(1)) u1 (
        .clk(clk), .rst(rst), .bus(if1.slave));
    hw_accel_stream_packer #(.IN_WIDTH(24), .OUT_WIDTH(8), .BYTE_ORDER(0)) u2 (
        .clk(clk), .rst(rst), .bus(if2.slave));

    int n_checks = 0;
    int n_fail   = 0;

    logic [23:0] stim_pix  [16];
    logic [31:0] obs0_data [16];
    logic [3:0]  obs0_en   [16];
    logic        obs0_last [16];
    logic [31:0] obs1_data [16];
    int          nobs0, nobs1, ir_low, hold_viol;
    logic        ir_trace  [64];

    // Drives stim_pix[0..npix-1] into u0 and u1 (eof on the last pixel),
    // applies an out_ready stall window and records the words taken.
    task automatic run_24_32(input int npix, input int stall_from, input int stall_len,
                             input int budget);
        int pi;
        logic prev_hold;
        logic [31:0] prev_data;
        logic saw_last;
        pi = 0; prev_hold = 1'b0; prev_data = '0; saw_last = 1'b0;
        nobs0 = 0; nobs1 = 0; ir_low = 0; hold_viol = 0;
        for (int i = 0; i < 16; i++) begin
            obs0_data[i] = '0; obs0_en[i] = '0; obs0_last[i] = 1'b0; obs1_data[i] = '0;
        end
        for (int i = 0; i < 64; i++) ir_trace[i] = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if0.out_ready = !((c >= stall_from) && (c < stall_from + stall_len));
            if1.out_ready = if0.out_ready;
            if (c < 64) ir_trace[c] = if0.in_ready;
            if (prev_hold && ((if0.out_valid !== 1'b1) || (if0.out_data !== prev_data)))
                hold_viol++;
            prev_hold = if0.out_valid && !if0.out_ready;
            prev_data = if0.out_data;
            if (if0.out_valid && if0.out_ready && nobs0 < 16) begin
                obs0_data[nobs0] = if0.out_data;
                obs0_en[nobs0]   = if0.out_byte_en;
                obs0_last[nobs0] = if0.out_last;
                if (if0.out_last) saw_last = 1'b1;
                nobs0++;
            end
            if (if1.out_valid && if1.out_ready && nobs1 < 16) begin
                obs1_data[nobs1] = if1.out_data;
                nobs1++;
            end
            if (pi < npix) begin
                if0.in_valid = 1'b1; if0.in_data = stim_pix[pi]; if0.in_eof = (pi == npix - 1);
                if1.in_valid = 1'b1; if1.in_data = stim_pix[pi]; if1.in_eof = (pi == npix - 1);
                if (!if0.in_ready) ir_low++;
                else pi++;
            end else begin
                if0.in_valid = 1'b0; if0.in_eof = 1'b0;
                if1.in_valid = 1'b0; if1.in_eof = 1'b0;
            end
            if (saw_last && pi >= npix) break;
        end
        if0.in_valid = 1'b0; if0.in_eof = 1'b0;
        if1.in_valid = 1'b0; if1.in_eof = 1'b0;
    endtask

    task automatic test_reset();
        if0.in_valid = 1'b1;
        if0.in_data  = 24'h112233;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({if0.out_valid, if0.out_last, if0.out_byte_en, if0.out_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_out0: got v=%b l=%b en=%h d=%h want all 0",
                     if0.out_valid, if0.out_last, if0.out_byte_en, if0.out_data);
        end
        n_checks++;
        if ({if1.out_valid, if1.out_last, if1.out_byte_en, if1.out_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_out1: got v=%b d=%h want all 0", if1.out_valid, if1.out_data);
        end
        n_checks++;
        if ({if2.out_valid, if2.out_last, if2.out_byte_en, if2.out_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_out2: got v=%b d=%h want all 0", if2.out_valid, if2.out_data);
        end
        n_checks++;
        if (if0.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 0", if0.in_ready);
        end
        if0.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (if0.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_in_ready: got %b want 1", if0.in_ready);
        end
    endtask

    task automatic test_rgb_pack();
        logic [31:0] exp_w [3];
        exp_w = '{32'h44332211, 32'h88776655, 32'hCCBBAA99};
        stim_pix[0] = 24'h112233; stim_pix[1] = 24'h445566;
        stim_pix[2] = 24'h778899; stim_pix[3] = 24'hAABBCC;
        run_24_32(4, 0, 0, 40);
        n_checks++;
        if (nobs0 !== 3) begin
            n_fail++; $display("FAIL rgb_count: got %0d words want 3", nobs0);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (obs0_data[i] !== exp_w[i] || obs0_en[i] !== 4'hF || obs0_last[i] !== (i == 2)) begin
                n_fail++;
                $display("FAIL rgb_word%0d: got d=%h en=%h l=%b want d=%h en=f l=%b",
                         i, obs0_data[i], obs0_en[i], obs0_last[i], exp_w[i], (i == 2));
            end
        end
        n_checks++;
        if (ir_low !== 0) begin
            n_fail++; $display("FAIL rgb_in_ready: got %0d low cycles want 0", ir_low);
        end
    endtask

    task automatic test_eof_partial();
        stim_pix[0] = 24'h112233; stim_pix[1] = 24'h445566;
        run_24_32(2, 0, 0, 30);
        n_checks++;
        if (nobs0 !== 2) begin
            n_fail++; $display("FAIL eof_count: got %0d words want 2", nobs0);
        end
        n_checks++;
        if (obs0_data[0] !== 32'h44332211 || obs0_en[0] !== 4'hF || obs0_last[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL eof_word0: got d=%h en=%h l=%b want d=44332211 en=f l=0",
                     obs0_data[0], obs0_en[0], obs0_last[0]);
        end
        n_checks++;
        if (obs0_data[1] !== 32'h00006655 || obs0_en[1] !== 4'h3 || obs0_last[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL eof_word1: got d=%h en=%h l=%b want d=00006655 en=3 l=1",
                     obs0_data[1], obs0_en[1], obs0_last[1]);
        end
        n_checks++;
        if (ir_trace[2] !== 1'b0) begin
            n_fail++; $display("FAIL eof_flush_block: got in_ready=%b want 0", ir_trace[2]);
        end
        @(negedge clk);
        n_checks++;
        if (if0.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL eof_ready_return: got in_ready=%b want 1", if0.in_ready);
        end
    endtask

    task automatic test_byte_order();
        logic [31:0] exp_w [3];
        // LSB-first stream: 33 22 11 66 55 44 99 88 77 CC BB AA
        exp_w = '{32'h66112233, 32'h88994455, 32'hAABBCC77};
        stim_pix[0] = 24'h112233; stim_pix[1] = 24'h445566;
        stim_pix[2] = 24'h778899; stim_pix[3] = 24'hAABBCC;
        run_24_32(4, 0, 0, 40);
        n_checks++;
        if (nobs1 !== 3) begin
            n_fail++; $display("FAIL order_count: got %0d words want 3", nobs1);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (obs1_data[i] !== exp_w[i]) begin
                n_fail++;
                $display("FAIL order_word%0d: got %h want %h", i, obs1_data[i], exp_w[i]);
            end
        end
    endtask

    task automatic test_back_to_back_stall();
        logic [31:0] exp_w [6];
        exp_w = '{32'h04030201, 32'h08070605, 32'h0C0B0A09,
                  32'h100F0E0D, 32'h14131211, 32'h18171615};
        for (int i = 0; i < 8; i++)
            stim_pix[i] = {8'(3*i+1), 8'(3*i+2), 8'(3*i+3)};
        run_24_32(8, 2, 10, 80);
        n_checks++;
        if (nobs0 !== 6) begin
            n_fail++; $display("FAIL stall_count: got %0d words want 6", nobs0);
        end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (obs0_data[i] !== exp_w[i] || obs0_last[i] !== (i == 5)) begin
                n_fail++;
                $display("FAIL stall_word%0d: got d=%h l=%b want d=%h l=%b",
                         i, obs0_data[i], obs0_last[i], exp_w[i], (i == 5));
            end
        end
        n_checks++;
        if (!(ir_low > 0)) begin
            n_fail++; $display("FAIL stall_in_ready: got %0d low cycles want >0", ir_low);
        end
        n_checks++;
        if (hold_viol !== 0) begin
            n_fail++; $display("FAIL stall_hold: got %0d changes while held want 0", hold_viol);
        end
    endtask

    task automatic test_narrow_out();
        logic [7:0]  exp_b [12];
        logic [23:0] pix   [4];
        int acc_cyc [4];
        int pi, nw;
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                  8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
        pix = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC};
        acc_cyc = '{-1, -1, -1, -1};
        pi = 0; nw = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if2.out_ready = 1'b1;
            if (if2.out_valid) begin
                if (nw < 12) begin
                    n_checks++;
                    if (if2.out_data !== exp_b[nw] || c !== nw + 1) begin
                        n_fail++;
                        $display("FAIL narrow_byte%0d: got %h at cycle %0d want %h at cycle %0d",
                                 nw, if2.out_data, c, exp_b[nw], nw + 1);
                    end
                end
                nw++;
            end
            if (pi < 4) begin
                if2.in_valid = 1'b1; if2.in_data = pix[pi]; if2.in_eof = 1'b0;
                if (if2.in_ready) begin
                    acc_cyc[pi] = c;
                    pi++;
                end
            end else begin
                if2.in_valid = 1'b0;
            end
        end
        if2.in_valid = 1'b0;
        n_checks++;
        if (nw !== 12) begin
            n_fail++; $display("FAIL narrow_count: got %0d words want 12", nw);
        end
        n_checks++;
        if (acc_cyc[0] !== 0 || acc_cyc[1] !== 2 || acc_cyc[2] !== 5 || acc_cyc[3] !== 8) begin
            n_fail++;
            $display("FAIL narrow_throttle: got accepts at %0d,%0d,%0d,%0d want 0,2,5,8",
                     acc_cyc[0], acc_cyc[1], acc_cyc[2], acc_cyc[3]);
        end
    endtask

    task automatic test_reset_midframe();
        @(negedge clk);
        if0.out_ready = 1'b0;
        if0.in_valid = 1'b1; if0.in_data = 24'h112233; if0.in_eof = 1'b0;
        @(negedge clk);
        if0.in_data = 24'h445566;
        @(negedge clk);
        if0.in_valid = 1'b0;
        n_checks++;
        if (if0.out_valid !== 1'b1 || if0.out_data !== 32'h44332211) begin
            n_fail++;
            $display("FAIL midframe_pre: got v=%b d=%h want v=1 d=44332211",
                     if0.out_valid, if0.out_data);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({if0.out_valid, if0.out_last, if0.out_byte_en, if0.out_data, if0.in_ready} !== '0) begin
            n_fail++;
            $display("FAIL midframe_reset: got v=%b en=%h d=%h rdy=%b want all 0",
                     if0.out_valid, if0.out_byte_en, if0.out_data, if0.in_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        if0.out_ready = 1'b1;
        stim_pix[0] = 24'hA1A2A3; stim_pix[1] = 24'hB1B2B3;
        run_24_32(2, 0, 0, 30);
        n_checks++;
        if (nobs0 !== 2 || obs0_data[0] !== 32'hB1A3A2A1 || obs0_last[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL midframe_word0: got n=%0d d=%h l=%b want n=2 d=b1a3a2a1 l=0",
                     nobs0, obs0_data[0], obs0_last[0]);
        end
        n_checks++;
        if (obs0_data[1] !== 32'h0000B3B2 || obs0_en[1] !== 4'h3 || obs0_last[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL midframe_word1: got d=%h en=%h l=%b want d=0000b3b2 en=3 l=1",
                     obs0_data[1], obs0_en[1], obs0_last[1]);
        end
    endtask

    initial begin
        rst = 1'b1;
        if0.in_data = '0; if0.in_valid = 1'b0; if0.in_eof = 1'b0; if0.out_ready = 1'b1;
        if1.in_data = '0; if1.in_valid = 1'b0; if1.in_eof = 1'b0; if1.out_ready = 1'b1;
        if2.in_data = '0; if2.in_valid = 1'b0; if2.in_eof = 1'b0; if2.out_ready = 1'b1;
        #2 rst = 1'b0;
        test_reset();
        test_rgb_pack();
        test_eof_partial();
        test_byte_order();
        test_back_to_back_stall();
        test_narrow_out();
        test_reset_midframe();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end
endmodule
